pixel_serializer: RTL and testbench
===================================

# pixel_serializer

Parametrised parallel-to-serial output stage for the edge-detection pipeline. It takes processed pixels (Sobel or pooling output) from the output FIFO over a valid/ready stream. It shifts each pixel out over `LANES` serial lines with a per-beat valid/ready handshake, and tracks a fixed frame length so it can flag the last beat and signal frame completion. It generalises the single-lane, 8-bit, fixed-order serial output with configurable pixel width, lane count, bit order and frame size.

## Interface
- `DATA_W`, 8: pixel width in bits.
- `LANES`, 1: serial lines per beat. Must divide `DATA_W`.
- `PIXEL_CNT`, 961: pixels per frame (3844 for Sobel 62x62, 3721 for pool stride 1, 961 for pool stride 2). Must be ≥1.
- `clk_200mhz`  in  1  sole clock; every register changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  frame start pulse; ignored while `busy`.
- `msb_first`  in  1  bit order, sampled on the accepted `start`.
- `pix_data`  in  DATA_W  pixel from the FIFO.
- `pix_valid`  in  1  pixel valid.
- `pix_ready`  out  1  pixel accept.
- `serial_data`  out  LANES  current beat.
- `serial_valid`  out  1  beat valid.
- `serial_ready_in`  in  1  sink ready.
- `frame_last`  out  1  qualifies the final beat of the frame.
- `frame_done`  out  1  one-cycle pulse after the final beat is accepted.
- `busy`  out  1  high from the accepted `start` until `frame_done`, inclusive.

## Operation
- The number of beats per pixel is `BEATS = DATA_W/LANES`, plus 1 with parity (see Configuration).
- The FSM has four states: IDLE, LOAD, SHIFT, DONE.
- **IDLE**: `start` latches `msb_first`, clears the pixel and beat counters, and moves to LOAD.
- **LOAD**:
  - `pix_ready` is 1.
  - On `pix_valid && pix_ready`, `pix_data` is captured into the shift register, the beat counter is zeroed, and the FSM moves to SHIFT.
- **SHIFT**:
  - `serial_valid` is 1. A beat transfers on `serial_valid && serial_ready_in`, which advances the beat counter.
  - On the transfer of the final beat:
    - if the pixel counter equals `PIXEL_CNT-1`, the FSM moves to DONE;
    - otherwise the pixel counter increments and the FSM moves to LOAD.
  - Fast path: during the final beat of a non-final pixel, `pix_ready = serial_ready_in`. A pixel accepted in that cycle is loaded directly and the FSM stays in SHIFT, so there is no bubble.
- **DONE**: `frame_done` is 1 for one cycle, then the FSM returns to IDLE.
- Bit order:
  - MSB-first: beat b carries bits `[DATA_W-1-b*LANES -: LANES]`.
  - LSB-first: beat b carries bits `[b*LANES +: LANES]`.
  - In both orders, lane index tracks bit significance.
- `frame_last` is `serial_valid` AND final pixel AND final beat.
- The pixel counter is `$clog2(PIXEL_CNT+1)` bits wide and never wraps within a frame.

## Timing
- Reset values: `pix_ready`, `serial_valid`, `serial_data`, `frame_last`, `frame_done` and `busy` are all 0; state is IDLE; counters are 0.
- Latency:
  - `start` in cycle t gives `pix_ready` in cycle t+1.
  - A pixel accepted in cycle t gives its first beat valid in cycle t+1.
  - The final beat accepted in cycle t gives `frame_done` in cycle t+1.
- Backpressure: while `serial_valid && !serial_ready_in`, `serial_data` and `frame_last` hold stable.
- Source gaps: while `pix_valid` is low in LOAD, `serial_valid` is 0; no beat is ever duplicated or dropped.
- `pix_ready` is combinational only on the fast path; all other outputs are registered or decoded from registered state.
- `reset` mid-frame: next cycle all outputs are at reset values. The partial pixel is discarded, and the next `start` begins at pixel 0.
- `start` while `busy` has no effect. `start` in the same cycle as `reset` is ignored.

## Configuration
- `SERIAL_PARITY_EN` defined:
  - One extra beat follows the data beats of each pixel.
  - Every lane carries the even parity (XOR) of the pixel.
  - `frame_last` accompanies the parity beat of the final pixel.
- `SERIAL_PARITY_EN` undefined: no parity beat; `BEATS = DATA_W/LANES`.

## Structure
- Package `pixel_ser_pkg` holds:
  - the FSM state enum;
  - a beats-per-pixel constant function;
  - frame-size constants (3844, 3721, 961).
- Sub-module `pixel_shift_reg` holds the pixel register, the beat counter and the order-selectable lane slicing. The top level keeps the FSM, pixel counter and handshakes.

## Test plan
- **Single lane, MSB-first**: `DATA_W=8`, `LANES=1`, `PIXEL_CNT=4`, `msb_first=1`, ready held at 1, pixels A5, 3C, FF, 00 → bit stream 10100101 00111100 11111111 00000000 (32 beats), `frame_last` on beat 32 only, `frame_done` one cycle later.
- **Two lanes, LSB-first**: `LANES=2`, `msb_first=0`, pixel B4 → beats 00, 01, 11, 10.
- **Random backpressure**: `PIXEL_CNT=961`, `serial_ready_in` high with 60% probability → 961 bytes received equal to those sent, `serial_data` stable on every stalled cycle.
- **Source gaps**: `pix_valid` low for 5 cycles between pixels → `serial_valid` low through the gap, no repeated beats. With no gaps and ready held at 1 → back-to-back pixels have no bubble.
- **Reset mid-frame**: `reset` during beat 3 of pixel 2 → all outputs 0 the next cycle. A new `start` delivers a complete 4-pixel frame from pixel 0.
- **Parity (`SERIAL_PARITY_EN`)**: A5 → 9th beat 0; 07 → 9th beat 1. With `LANES=2` the parity bit appears on both lanes.

Source files
------------

// File: rtl/pixel_serializer_pkg.sv
// pixel_ser_pkg: FSM states, frame sizes and beats-per-pixel (parity beat added under SERIAL_PARITY_EN)
package pixel_ser_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  localparam int SOBEL_62X62_PIX = 3844;
  localparam int POOL_S1_PIX = 3721;
  localparam int POOL_S2_PIX = 961;
  function automatic int beats_per_pixel(input int data_w, input int lanes);
`ifdef SERIAL_PARITY_EN
    return data_w / lanes + 1;
`else
    return data_w / lanes;
`endif
  endfunction
endpackage

// File: rtl/pixel_serializer_if.sv
// pixel_serializer_if: pixel-in / serial-out stream bundle; master drives, slave is the serializer
interface pixel_serializer_if #(parameter int DATA_W = 8, parameter int LANES = 1);
  logic start, msb_first, pix_valid, pix_ready, serial_valid, serial_ready_in;
  logic frame_last, frame_done, busy;
  logic [DATA_W-1:0] pix_data;
  logic [LANES-1:0] serial_data;
  modport master (
    output start, msb_first, pix_data, pix_valid, serial_ready_in,
    input pix_ready, serial_data, serial_valid, frame_last, frame_done, busy
  );
  modport slave (
    input start, msb_first, pix_data, pix_valid, serial_ready_in,
    output pix_ready, serial_data, serial_valid, frame_last, frame_done, busy
  );
endinterface

// File: rtl/pixel_serializer_shift_reg.sv
// pixel_shift_reg: pixel register, beat counter and lane slicing; parity beat under SERIAL_PARITY_EN
module pixel_shift_reg
  import pixel_ser_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_adv,
  input  logic              i_valid,
  input  logic              i_msb_first,
  input  logic [DATA_W-1:0] i_data,
  output logic [LANES-1:0]  o_data,
  output logic              o_last_beat
);
  localparam int BEATS = beats_per_pixel(DATA_W, LANES);
  localparam int DB = DATA_W / LANES;
  localparam int BW = $clog2(BEATS + 1);
  localparam int IW = $clog2(DATA_W);
  logic [DATA_W-1:0] r_pix;
  logic [BW-1:0] r_beat;
  logic [IW-1:0] w_lo;
  always_ff @(posedge clk)
    if (rst) begin
      r_pix  <= '0;
      r_beat <= '0;
    end else if (i_load) begin
      r_pix  <= i_data;
      r_beat <= '0;
    end else if (i_adv) r_beat <= o_last_beat ? '0 : r_beat + 1'b1;
  assign o_last_beat = r_beat == BW'(BEATS - 1);
  // lowest bit index of the current beat; lane 0 always carries the least significant bit
  assign w_lo = IW'(i_msb_first ? (DB - 1 - int'(r_beat)) * LANES : int'(r_beat) * LANES);
  always_comb
    o_data = !i_valid ? '0
           : (BEATS > DB && r_beat == BW'(DB)) ? {LANES{^r_pix}}
           : r_pix[w_lo +: LANES];
endmodule

// File: rtl/pixel_serializer.sv
// pixel_serializer: frame-length pixel-to-LANES serializer with zero-bubble reload; SERIAL_PARITY_EN adds a parity beat
module pixel_serializer
  import pixel_ser_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LANES     = 1,
  parameter int PIXEL_CNT = 961
) (
  input logic               clk_200mhz,
  input logic               reset,
  pixel_serializer_if.slave bus
);
  localparam int PW = $clog2(PIXEL_CNT + 1);
  state_t r_state;
  logic [PW-1:0] r_pix_cnt;
  logic r_msb_first, w_last_beat, w_beat_xfer, w_final_pix, w_load;
  assign w_final_pix = r_pix_cnt == PW'(PIXEL_CNT - 1);
  assign bus.serial_valid = r_state == SHIFT;
  assign w_beat_xfer = bus.serial_valid && bus.serial_ready_in;
  // fast path: next pixel may enter while the last beat of a non-final pixel leaves
  assign bus.pix_ready = r_state == LOAD || (w_beat_xfer && w_last_beat && !w_final_pix);
  assign w_load = bus.pix_valid && bus.pix_ready;
  assign bus.frame_last = bus.serial_valid && w_final_pix && w_last_beat;
  assign bus.frame_done = r_state == DONE;
  assign bus.busy = r_state != IDLE;
  always_ff @(posedge clk_200mhz)
    if (reset) begin
      r_state     <= IDLE;
      r_pix_cnt   <= '0;
      r_msb_first <= 1'b0;
    end else
      case (r_state)
        IDLE:
          if (bus.start) begin
            r_state     <= LOAD;
            r_pix_cnt   <= '0;
            r_msb_first <= bus.msb_first;
          end
        LOAD: if (w_load) r_state <= SHIFT;
        SHIFT:
          if (w_beat_xfer && w_last_beat) begin
            if (w_final_pix) r_state <= DONE;
            else begin
              r_pix_cnt <= r_pix_cnt + 1'b1;
              r_state   <= w_load ? SHIFT : LOAD;
            end
          end
        default: r_state <= IDLE;
      endcase
  pixel_shift_reg #(.DATA_W(DATA_W), .LANES(LANES)) u_shift (
    .clk         (clk_200mhz),
    .rst         (reset),
    .i_load      (w_load),
    .i_adv       (w_beat_xfer),
    .i_valid     (bus.serial_valid),
    .i_msb_first (r_msb_first),
    .i_data      (bus.pix_data),
    .o_data      (bus.serial_data),
    .o_last_beat (w_last_beat)
  );
endmodule

// File: tb/tb_pixel_serializer.sv
// tb_pixel_serializer: two serializer configurations checked against a bit-order stream model
module tb_pixel_serializer;
`ifdef SERIAL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int BA = 8 + PAR;
  localparam int BB = 4 + PAR;
  localparam int NB = 961;
  logic clk = 0, reset = 1, start = 0, msb_first = 0, pv = 0, srdy = 0, sel = 0;
  logic [7:0] pd = 0;
  logic [1:0] sd;
  logic sv, pr, fl, fd, bz;
  int checks = 0, passed = 0, cyc = 0, gap = 0, gap_cnt = 0, bubbles = 0, done_cyc = -1, last_cyc = -1;
  bit in_frame = 0, stalled = 0, bz_done = 0;
  logic [2:0] held;
  logic [7:0] src[$], sent[$];
  logic [2:0] got[$];
  logic [31:0] stream;

  always #5 clk = ~clk;

  pixel_serializer_if #(.DATA_W(8), .LANES(1)) ia ();
  pixel_serializer_if #(.DATA_W(8), .LANES(2)) ib ();
  pixel_serializer #(.DATA_W(8), .LANES(1), .PIXEL_CNT(4)) dut_a (.clk_200mhz(clk), .reset(reset), .bus(ia));
  pixel_serializer #(.DATA_W(8), .LANES(2), .PIXEL_CNT(NB)) dut_b (.clk_200mhz(clk), .reset(reset), .bus(ib));

  assign ia.start = start & ~sel;
  assign ib.start = start & sel;
  assign ia.msb_first = msb_first;
  assign ib.msb_first = msb_first;
  assign ia.pix_data = pd;
  assign ib.pix_data = pd;
  assign ia.pix_valid = pv;
  assign ib.pix_valid = pv;
  assign ia.serial_ready_in = srdy;
  assign ib.serial_ready_in = srdy;
  assign sd = sel ? ib.serial_data : {1'b0, ia.serial_data};
  assign sv = sel ? ib.serial_valid : ia.serial_valid;
  assign pr = sel ? ib.pix_ready : ia.pix_ready;
  assign fl = sel ? ib.frame_last : ia.frame_last;
  assign fd = sel ? ib.frame_done : ia.frame_done;
  assign bz = sel ? ib.busy : ia.busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // beat b of pixel p: MSB-first walks down from the top, LSB-first up from bit 0; extra beat is parity
  function automatic logic [1:0] exp_beat(input logic [7:0] p, input int b, input int lanes, input bit msb);
    int pos;
    if (b == 8 / lanes) return lanes == 2 ? {2{^p}} : {1'b0, ^p};
    pos = msb ? 8 - (b + 1) * lanes : b * lanes;
    return lanes == 2 ? {p[pos+1], p[pos]} : {1'b0, p[pos]};
  endfunction

  task automatic step(input bit rdy);
    @(posedge clk);
    #1;
    pv = src.size() > 0 && gap_cnt == 0;
    pd = pv ? src[0] : 8'($urandom);
    srdy = rdy;
    @(negedge clk);
    cyc++;
    if (stalled) chk("stall_hold", {sv, fl, sd}, {1'b1, held});
    stalled = sv && !srdy;
    held = {fl, sd};
    if (sv && srdy) begin
      got.push_back({fl, sd});
      last_cyc = cyc;
      in_frame = !fl;
    end else if (in_frame && !sv) bubbles++;
    if (pv && pr) begin
      void'(src.pop_front());
      gap_cnt = gap;
    end else if (pr && gap_cnt > 0) gap_cnt--;
    if (fd) begin
      done_cyc = cyc;
      bz_done = bz;
    end
  endtask

  task automatic run_frame(input bit s, input bit msb, input int prob, input int gap_len, input string tag);
    int bpp, lanes, n;
    bpp = s ? BB : BA;
    lanes = s ? 2 : 1;
    n = sent.size();
    sel = s;
    src = sent;
    got.delete();
    gap = gap_len;
    gap_cnt = 0;
    bubbles = 0;
    in_frame = 0;
    stalled = 0;
    done_cyc = -1;
    last_cyc = -1;
    start = 1;
    msb_first = msb;
    step(1);
    start = 0;
    chk({tag, "_start_ready"}, {bz, pr}, 2'b11);
    for (int c = 0; c < 20000 && done_cyc < 0; c++) step(prob >= 100 || $urandom_range(99) < prob);
    chk({tag, "_done_seen"}, done_cyc >= 0, 1);
    chk({tag, "_beat_count"}, got.size(), n * bpp);
    for (int k = 0; k < n * bpp; k++)
      chk($sformatf("%s_beat%0d", tag, k), got[k], {k == n * bpp - 1, exp_beat(sent[k / bpp], k % bpp, lanes, msb)});
    chk({tag, "_done_latency"}, done_cyc, last_cyc + 1);
    chk({tag, "_busy_at_done"}, bz_done, 1);
    if (prob >= 100) chk({tag, "_bubbles"}, bubbles, (n - 1) * gap_len);
    step(1);
    chk({tag, "_done_pulse"}, {fd, bz}, 0);
  endtask

  initial begin
    reset = 1;
    repeat (3) step(0);
    chk("rst_a", {ia.pix_ready, ia.serial_valid, ia.serial_data, ia.frame_last, ia.frame_done, ia.busy}, 0);
    chk("rst_b", {ib.pix_ready, ib.serial_valid, ib.serial_data, ib.frame_last, ib.frame_done, ib.busy}, 0);
    reset = 0;
    step(1);

    sent = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    run_frame(0, 1, 100, 0, "msb1");
    stream = 0;
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 8; b++) stream = {stream[30:0], got[p * BA + b][0]};
    chk("msb1_stream", stream, 32'hA53CFF00);

    sent = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    run_frame(0, 0, 100, 5, "gap5");

    sent = '{8'h11, 8'h22, 8'h33, 8'h44};
    sel = 0;
    src = sent;
    got.delete();
    gap = 0;
    gap_cnt = 0;
    in_frame = 0;
    start = 1;
    msb_first = 1;
    step(1);
    start = 0;
    for (int c = 0; c < 200 && got.size() < 2 * BA + 2; c++) step(1);
    chk("mid_reached", got.size(), 2 * BA + 2);
    reset = 1;
    start = 1;
    stalled = 0;
    step(1);
    chk("mid_rst_zero", {ia.pix_ready, ia.serial_valid, ia.serial_data, ia.frame_last, ia.frame_done, ia.busy}, 0);
    reset = 0;
    start = 0;
    step(1);
    chk("start_in_rst_ignored", ia.busy, 0);
    sent = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    run_frame(0, 1, 70, 0, "after_rst");

`ifdef SERIAL_PARITY_EN
    sent = '{8'hA5, 8'h07, 8'h13, 8'h00};
    run_frame(0, 1, 100, 0, "par");
    chk("par_a5", got[8][1:0], 0);
    chk("par_07", got[BA + 8][1:0], 1);
`endif

    sent.delete();
    sent.push_back(8'hB4);
    sent.push_back(8'h07);
    for (int i = 2; i < NB; i++) sent.push_back(8'($urandom));
    run_frame(1, 0, 60, 0, "lanes2");
    chk("b4_beat0", got[0][1:0], 2'b00);
    chk("b4_beat1", got[1][1:0], 2'b01);
    chk("b4_beat2", got[2][1:0], 2'b11);
    chk("b4_beat3", got[3][1:0], 2'b10);
`ifdef SERIAL_PARITY_EN
    chk("par_b4_lanes", got[4][1:0], 2'b00);
    chk("par_07_lanes", got[BB + 4][1:0], 2'b11);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
